guess_round_ctrl: RTL

GUESS_ROUND_CTRL -- requirements
Module: guess_round_ctrl

---
 rtl/guess_round_ctrl.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/guess_round_ctrl.sv
// Round controller for a symbol-sequence guessing game.
// Captures a secret sequence from four symbol buttons, then accepts up to
// MAX_TURNS guesses. Each guess is handed to an external comparator, and the
// round ends in WIN or LOSE. The sequence store and comparator sit outside
// this block; it drives their write and compare strobes.
module guess_round_ctrl #(
    parameter int MAX_LEN   = 7,
    parameter int MIN_LEN   = 4,
    parameter int MAX_TURNS = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] btn,
    input  logic       enter,
    output logic       wr_en,
    output logic       wr_sel,
    output logic [2:0] wr_slot,
    output logic [1:0] wr_sym,
    output logic       clr_guess,
    output logic       cmp_req,
    input  logic       cmp_done,
    input  logic       cmp_match,
    output logic [2:0] phase,
    output logic [1:0] turn,
    output logic [2:0] len_rel,
    output logic       win,
    output logic       lose
);

    typedef enum logic [2:0] {
        PH_SECRET = 3'd0,
        PH_GUESS  = 3'd1,
        PH_CMP    = 3'd2,
        PH_WIN    = 3'd3,
        PH_LOSE   = 3'd4
    } phase_t;

    localparam logic [2:0] MAX_LEN_C   = 3'(MAX_LEN);
    localparam logic [2:0] MIN_LEN_C   = 3'(MIN_LEN);
    localparam logic [1:0] MAX_TURNS_C = 2'(MAX_TURNS);

    // len_rel encoding {smaller, equal, bigger}
    localparam logic [2:0] REL_SMALLER = 3'b100;
    localparam logic [2:0] REL_EQUAL   = 3'b010;
    localparam logic [2:0] REL_BIGGER  = 3'b001;

    phase_t     state, state_n;
    logic [2:0] scount, scount_n;
    logic [2:0] gcount, gcount_n;
    logic [1:0] turn_n, turn_inc;

    // Edge-detect history; armed is low for the first cycle after reset so a
    // button held across reset deassert only loads the history.
    logic [3:0] btn_q;
    logic       enter_q;
    logic       armed;

    logic [3:0] btn_rise;
    logic       btn_hit;
    logic [1:0] btn_idx;
    logic       enter_rise;

    logic       wr_en_n, wr_sel_n, clr_guess_n, cmp_req_n, win_n, lose_n;
    logic [2:0] wr_slot_n, len_rel_n;
    logic [1:0] wr_sym_n;

    assign phase = state;

    // Press detection: rising edges only, lowest-index button has priority.
    always_comb begin
        btn_rise   = armed ? (btn & ~btn_q) : 4'b0000;
        enter_rise = armed & enter & ~enter_q;
        btn_hit    = |btn_rise;
        btn_idx    = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (btn_rise[i]) btn_idx = 2'(i);
        end
    end

    // Next-state and registered-output values for the round FSM.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path can leave one unassigned (no latches).
        state_n     = state;
        scount_n    = scount;
        gcount_n    = gcount;
        turn_n      = turn;
        turn_inc    = turn + 2'd1;
        wr_en_n     = 1'b0;
        wr_sel_n    = wr_sel;
        wr_slot_n   = wr_slot;
        wr_sym_n    = wr_sym;
        clr_guess_n = 1'b0;
        cmp_req_n   = cmp_req;
        len_rel_n   = len_rel;
        win_n       = win;
        lose_n      = lose;

        case (state)
            PH_SECRET: begin
                if (btn_hit) begin
                    // a button edge always swallows a same-cycle enter edge
                    if (scount < MAX_LEN_C) begin
                        wr_en_n   = 1'b1;
                        wr_sel_n  = 1'b0;
                        wr_slot_n = scount;
                        wr_sym_n  = btn_idx;
                        scount_n  = scount + 3'd1;
                    end
                end else if (enter_rise && (scount >= MIN_LEN_C)) begin
                    state_n  = PH_GUESS;
                    gcount_n = 3'd0;
                end
            end

            PH_GUESS: begin
                if (btn_hit) begin
                    if (gcount < MAX_LEN_C) begin
                        wr_en_n   = 1'b1;
                        wr_sel_n  = 1'b1;
                        wr_slot_n = gcount;
                        wr_sym_n  = btn_idx;
                        gcount_n  = gcount + 3'd1;
                    end
                end else if (enter_rise && (gcount >= MIN_LEN_C)) begin
                    state_n   = PH_CMP;
                    cmp_req_n = 1'b1;
                    if (gcount > scount)       len_rel_n = REL_SMALLER;
                    else if (gcount == scount) len_rel_n = REL_EQUAL;
                    else                       len_rel_n = REL_BIGGER;
                end
            end

            PH_CMP: begin
                if (cmp_done) begin
                    cmp_req_n = 1'b0;
                    if (cmp_match && (gcount == scount)) begin
                        state_n   = PH_WIN;
                        win_n     = 1'b1;
                        len_rel_n = REL_EQUAL;
                    end else begin
                        if (turn != MAX_TURNS_C) turn_n = turn_inc;
                        if (turn_inc == MAX_TURNS_C) begin
                            state_n = PH_LOSE;
                            lose_n  = 1'b1;
                        end else begin
                            state_n     = PH_GUESS;
                            clr_guess_n = 1'b1;
                            gcount_n    = 3'd0;
                        end
                    end
                end
            end

            PH_WIN, PH_LOSE: begin
                // terminal until reset
            end

            default: state_n = PH_SECRET;
        endcase
    end

    // State, counters, edge history and all outputs; reset clears everything at once.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state     <= PH_SECRET;
            scount    <= 3'd0;
            gcount    <= 3'd0;
            turn      <= 2'd0;
            btn_q     <= 4'b0000;
            enter_q   <= 1'b0;
            armed     <= 1'b0;
            wr_en     <= 1'b0;
            wr_sel    <= 1'b0;
            wr_slot   <= 3'd0;
            wr_sym    <= 2'd0;
            clr_guess <= 1'b0;
            cmp_req   <= 1'b0;
            len_rel   <= 3'b000;
            win       <= 1'b0;
            lose      <= 1'b0;
        end else begin
            state     <= state_n;
            scount    <= scount_n;
            gcount    <= gcount_n;
            turn      <= turn_n;
            btn_q     <= btn;
            enter_q   <= enter;
            armed     <= 1'b1;
            wr_en     <= wr_en_n;
            wr_sel    <= wr_sel_n;
            wr_slot   <= wr_slot_n;
            wr_sym    <= wr_sym_n;
            clr_guess <= clr_guess_n;
            cmp_req   <= cmp_req_n;
            len_rel   <= len_rel_n;
            win       <= win_n;
            lose      <= lose_n;
        end
    end

endmodule
